// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; define DIV_FAST_EN to finish special cases early
module div_unit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  kill,
  output logic                  busy,
  output logic                  valid,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, result_q, result_d;
  logic sel_rem_q, sel_rem_d, qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic valid_q, valid_d, dbz_q, dbz_d;
  logic sgn, b_zero, accept, fast, ge;
  logic [W-1:0] a_abs, b_abs, quo_init, rem_init, quo_fix, rem_fix;
  logic [W:0] shifted, diff;

  assign sgn      = ~op[0];
  assign a_abs    = (sgn && A[W-1]) ? -A : A;
  assign b_abs    = (sgn && B[W-1]) ? -B : B;
  assign b_zero   = B == '0;
  assign accept   = state_q == IDLE && start && !kill;
  assign shifted  = {rem_q, quo_q[W-1]};
  assign diff     = shifted - {1'b0, dvsr_q};
  assign ge       = ~diff[W];
  assign quo_fix  = bz_q ? '1 : qneg_q ? -quo_q : quo_q;
  assign rem_fix  = rneg_q ? -rem_q : rem_q;

`ifdef DIV_FAST_EN
  logic ovf, small;
  assign ovf      = sgn && A == {1'b1, {(W-1){1'b0}}} && B == '1;
  assign small    = op[0] && A < B;
  assign fast     = b_zero | ovf | small;
  assign quo_init = b_zero ? '1 : small ? '0 : a_abs;
  assign rem_init = (b_zero | small) ? a_abs : '0;
`else
  assign fast     = 1'b0;
  assign quo_init = a_abs;
  assign rem_init = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      sel_rem_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      bz_q      <= 1'b0;
      valid_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      sel_rem_q <= sel_rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      bz_q      <= bz_d;
      valid_q   <= valid_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (fast ? DONE : CALC) : IDLE;
      CALC:    state_d = cnt_q == CW'(1) ? DONE : CALC;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    sel_rem_d = sel_rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    bz_d      = bz_q;
    dbz_d     = dbz_q;
    valid_d   = 1'b0;
    if (kill) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d     = fast ? '0 : CW'(W);
      rem_d     = rem_init;
      quo_d     = quo_init;
      dvsr_d    = b_abs;
      sel_rem_d = op[1];
      qneg_d    = sgn & (A[W-1] ^ B[W-1]);
      rneg_d    = sgn & A[W-1];
      bz_d      = b_zero;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q - CW'(1);
      rem_d = ge ? diff[W-1:0] : shifted[W-1:0];
      quo_d = {quo_q[W-2:0], ge};
    end else if (state_q == DONE) begin
      result_d = sel_rem_q ? rem_fix : quo_fix;
      dbz_d    = bz_q;
      valid_d  = 1'b1;
    end
  end

  assign busy        = state_q != IDLE;
  assign valid       = valid_q;
  assign div_by_zero = dbz_q;
  assign result      = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against a cycle-count/arithmetic reference model
module tb_div_unit;
  localparam int W = 64;
`ifdef DIV_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
  logic [1:0] op = 2'd0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, valid, dbz;
  logic [W-1:0] result;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b), .kill(kill),
    .busy(busy), .valid(valid), .div_by_zero(dbz), .result(result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] q, r;
    if (y == '0) begin
      q = '1; r = x;
    end else if (!o[0] && x == MIN && y == '1) begin
      q = x; r = '0;
    end else if (!o[0]) begin
      q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
    end else begin
      q = x / y; r = x % y;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (FAST && (y == '0 || (!o[0] && x == MIN && y == '1) || (o[0] && x < y))) return 2;
    return W + 2;
  endfunction

  // Protocol model: outputs as seen after each rising edge
  logic m_busy = 1'b0, m_valid = 1'b0, m_dbz = 1'b0, m_pdbz = 1'b0;
  logic [W-1:0] m_result = '0, m_pend = '0;
  int m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_dbz = 1'b0; m_result = '0; m_left = 0;
    end else if (kill) begin
      m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      m_valid = m_left == 0;
      if (m_valid) begin
        m_busy = 1'b0; m_result = m_pend; m_dbz = m_pdbz;
      end
    end else begin
      m_valid = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_pend = ref_res(op, a, b);
        m_pdbz = b == '0;
        m_left = ref_lat(op, a, b) - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", W'(busy), W'(m_busy));
      chk("valid", W'(valid), W'(m_valid));
      chk("result", result, m_result);
      if (m_valid) chk("div_by_zero", W'(dbz), W'(m_dbz));
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_res, input logic exp_dbz, input int exp_lat);
    int lat = 0;
    op = o; a = x; b = y; start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!valid && lat < 200);
    chk({name, " valid"}, W'(valid), W'(1));
    chk({name, " latency"}, W'(lat), W'(exp_lat));
    chk({name, " result"}, result, exp_res);
    chk({name, " dbz"}, W'(dbz), W'(exp_dbz));
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #5ms;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c, kill_at, cls, vcount;
    repeat (2) @(negedge clk);
    chk("reset busy", W'(busy), W'(0));
    chk("reset valid", W'(valid), W'(0));
    chk("reset result", result, '0);
    chk("reset dbz", W'(dbz), W'(0));
    check_en = 1'b1;
    rst = 1'b0;

    chk("model divu", ref_res(2'b01, 64'd100, 64'd7), 64'd14);
    chk("model remu", ref_res(2'b11, 64'd100, 64'd7), 64'd2);
    chk("model div neg", ref_res(2'b00, -64'd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model rem neg", ref_res(2'b10, -64'd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model rem negb", ref_res(2'b10, 64'd7, -64'd2), 64'd1);
    chk("model div ovf", ref_res(2'b00, MIN, '1), MIN);

    @(negedge clk);
    run_op("divu 100/7", 2'b01, 64'd100, 64'd7, 64'd14, 1'b0, 66);
    run_op("remu 100/7", 2'b11, 64'd100, 64'd7, 64'd2, 1'b0, 66);
    run_op("div -7/2", 2'b00, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 66);
    run_op("rem -7/2", 2'b10, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
    run_op("rem 7/-2", 2'b10, 64'd7, -64'd2, 64'd1, 1'b0, 66);
    run_op("divu 5/0", 2'b01, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, FAST ? 2 : 66);
    run_op("remu 5/0", 2'b11, 64'd5, 64'd0, 64'd5, 1'b1, FAST ? 2 : 66);
    run_op("div -9/0", 2'b00, -64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, FAST ? 2 : 66);
    run_op("rem -9/0", 2'b10, -64'd9, 64'd0, -64'd9, 1'b1, FAST ? 2 : 66);
    run_op("div ovf", 2'b00, MIN, '1, MIN, 1'b0, FAST ? 2 : 66);
    run_op("rem ovf", 2'b10, MIN, '1, 64'd0, 1'b0, FAST ? 2 : 66);
    run_op("remu small", 2'b11, 64'd3, 64'd9, 64'd3, 1'b0, FAST ? 2 : 66);

    // start while busy must be ignored
    repeat (2) @(negedge clk);
    op = 2'b01; a = 64'd100; b = 64'd7; start = 1'b1; c = 0;
    do begin
      @(negedge clk);
      c++;
      start = c == 10;
      if (c == 10) begin a = 64'd1; b = 64'd1; end
    end while (!valid && c < 200);
    start = 1'b0;
    chk("ignore start latency", W'(c), W'(66));
    chk("ignore start result", result, 64'd14);

    // kill mid-operation
    @(negedge clk);
    op = 2'b01; a = 64'd1000; b = 64'd3; start = 1'b1; c = 0;
    do begin @(negedge clk); c++; start = 1'b0; end while (c < 30);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy", W'(busy), W'(0));
    chk("kill result", result, 64'd14);
    vcount = 0;
    repeat (70) begin @(negedge clk); if (valid) vcount++; end
    chk("kill no valid", W'(vcount), W'(0));

    // reset mid-operation
    op = 2'b00; a = -64'd12345; b = 64'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", W'(busy), W'(0));
    chk("rst valid", W'(valid), W'(0));
    chk("rst result", result, '0);
    chk("rst dbz", W'(dbz), W'(0));

    // randomized traffic with back-to-back starts, noise starts and kills
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      cls = int'($urandom_range(0, 5));
      op = 2'($urandom_range(0, 3));
      case (cls)
        0: begin a = rnd64(); b = rnd64(); end
        1: begin a = rnd64(); b = '0; end
        2: begin a = MIN; b = '1; end
        3: begin a = rnd64(); b = 64'($urandom_range(1, 15)); if ($urandom_range(0, 1) == 1) b = -b; end
        4: begin b = rnd64(); a = b >> $urandom_range(1, 20); end
        default: begin a = -64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
      endcase
      kill_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 70)) : 0;
      start = 1'b1; c = 0;
      do begin
        @(negedge clk);
        c++;
        start = 1'b0;
        kill = 1'b0;
        if (c == kill_at) kill = 1'b1;
        else if (m_busy && $urandom_range(0, 15) == 0) begin
          start = 1'b1; a = rnd64(); b = rnd64(); op = 2'($urandom_range(0, 3));
        end
      end while ((m_busy || kill) && c < 300);
      start = 1'b0;
      kill = 1'b0;
      chk("random op completes", W'(c < 300), W'(1));
    end

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
